// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multiport register file and its scoreboard.
package rf_pkg;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_CNT_W  = 2;

  // Largest pending-write count a CNT_W-bit counter can hold.
  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  // Low bit of field idx in a packed vector of w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_sb_cnt.sv
// One register's pending-write counter: saturating up by one, down by up to DEC_W-bit amount.
module rf_sb_cnt
  import rf_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DEC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam int unsigned      SumW   = CNT_W + DEC_W + 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_ok;
  logic [SumW-1:0]  sum, dec_ext;

  always_comb begin
    err     = 1'b0;
    inc_ok  = inc && (cnt_q != CntMax);
    sum     = SumW'(cnt_q) + SumW'(inc_ok);
    dec_ext = SumW'(dec);
    if (inc && (cnt_q == CntMax)) begin
      err = 1'b1;
    end
    // Retiring more writes than are outstanding floors the count at zero.
    if (dec_ext > sum) begin
      cnt_d = '0;
      err   = 1'b1;
    end else begin
      cnt_d = CNT_W'(sum - dec_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport register file with write-to-read bypass and per-register pending-write scoreboard.
// Define RF_TRACE_EN to print a trace line for every committed write.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*32-1:0]     wr_pc,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic                     sb_full,
  output logic                     sb_err
);

  localparam int unsigned      Depth  = 2 ** ADDR_W;
  localparam int unsigned      DecW   = 2;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));
  localparam logic [ADDR_W-1:0] Zero  = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [Depth];
  logic [CNT_W-1:0]  cnt    [Depth];
  logic [DecW-1:0]   dec    [Depth];
  logic [Depth-1:0]  err_vec;
  logic              sb_err_q;

  // Number of write ports retiring into each register this cycle.
  always_comb begin
    for (int r = 0; r < Depth; r++) begin
      dec[r] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (r != REG_ZERO && wr_en[p] &&
            wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(r)) begin
          dec[r] = dec[r] + DecW'(1);
        end
      end
    end
  end

  for (genvar r = 0; r < Depth; r++) begin : g_cnt
    if (r == REG_ZERO) begin : g_zero
      assign cnt[r]     = '0;
      assign err_vec[r] = 1'b0;
    end else begin : g_reg
      rf_sb_cnt #(
        .CNT_W(CNT_W),
        .DEC_W(DecW)
      ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (sb_set && (sb_set_addr == ADDR_W'(r))),
        .dec  (dec[r]),
        .cnt  (cnt[r]),
        .err  (err_vec[r])
      );
    end
  end

  // Later ports overwrite earlier ones, so the youngest write wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < Depth; r++) begin
        regs_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] != Zero) begin
          regs_q[wr_addr[slice_lo(p, ADDR_W) +: ADDR_W]] <=
            wr_data[slice_lo(p, DATA_W) +: DATA_W];
        end
      end
      if (|err_vec) begin
        sb_err_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;

    assign idx = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

    always_comb begin
      data = regs_q[idx];
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == idx) begin
          data = wr_data[slice_lo(p, DATA_W) +: DATA_W];
        end
      end
      if (idx == Zero) begin
        data = '0;
      end
    end

    assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = data;
    // Busy only if writes remain outstanding after this cycle's retires.
    assign rd_busy[i] = int'(cnt[idx]) > int'(dec[idx]);
  end

  assign sb_full = (cnt[sb_set_addr] == CntMax);
  assign sb_err  = sb_err_q;

`ifdef RF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] != Zero) begin
          $display("%d@%h: $%d <= %h", $time, wr_pc[slice_lo(p, 32) +: 32],
                   wr_addr[slice_lo(p, ADDR_W) +: ADDR_W],
                   wr_data[slice_lo(p, DATA_W) +: DATA_W]);
        end
      end
    end
  end
`else
  logic unused_wr_pc;
  assign unused_wr_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed self-checking bench for rf_multiport_sb at default parameters.
module tb_rf_multiport_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] wr_pc;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic        sb_full;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_multiport_sb dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_pc      (wr_pc),
    .sb_set     (sb_set),
    .sb_set_addr(sb_set_addr),
    .sb_full    (sb_full),
    .sb_err     (sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    sb_set = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    rd_addr     = '0;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_pc       = {32'h0000_1004, 32'h0000_1000};
    sb_set      = 1'b0;
    sb_set_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Every index reads zero and idle after reset.
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      chk("rst_rd0", rd_data[31:0], 32'h0);
      chk("rst_rd1", rd_data[63:32], 32'h0);
      chk("rst_busy", {30'b0, rd_busy}, 32'h0);
    end
    chk("rst_err", {31'b0, sb_err}, 32'h0);
    chk("rst_full", {31'b0, sb_full}, 32'h0);

    // Port0 write r5 with same-cycle read: bypass, then array.
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'h0000_1234};
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("byp_r5", rd_data[31:0], 32'h0000_1234);
    tick();
    idle();
    #1;
    chk("arr_r5", rd_data[31:0], 32'h0000_1234);
    // That write retired a register with no pending set.
    chk("err_retire_cnt0", {31'b0, sb_err}, 32'h1);

    // Both ports write r7: port1 wins bypass and storage.
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h0000_BBBB, 32'h0000_AAAA};
    rd_addr = {5'd7, 5'd5};
    #1;
    chk("coll_byp", rd_data[63:32], 32'h0000_BBBB);
    chk("r5_other_port", rd_data[31:0], 32'h0000_1234);
    tick();
    idle();
    rd_addr = {5'd7, 5'd7};
    #1;
    chk("coll_arr1", rd_data[63:32], 32'h0000_BBBB);
    chk("coll_arr0", rd_data[31:0], 32'h0000_BBBB);

    // r0 write and set are ignored.
    wr_en       = 2'b01;
    wr_addr     = {5'd0, 5'd0};
    wr_data     = {32'h0, 32'h0000_FFFF};
    sb_set      = 1'b1;
    sb_set_addr = 5'd0;
    rd_addr     = {5'd0, 5'd0};
    #1;
    chk("r0_byp", rd_data[31:0], 32'h0);
    chk("r0_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("r0_full", {31'b0, sb_full}, 32'h0);
    tick();
    idle();
    #1;
    chk("r0_arr", rd_data[31:0], 32'h0);
    chk("r0_busy_after", {31'b0, rd_busy[0]}, 32'h0);

    // Clear sticky error and storage with a reset pulse.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    rd_addr = {5'd5, 5'd7};
    #1;
    chk("rst2_err", {31'b0, sb_err}, 32'h0);
    chk("rst2_r7", rd_data[31:0], 32'h0);
    chk("rst2_r5", rd_data[63:32], 32'h0);

    // Fill r3 to max, overflow, then drain.
    sb_set      = 1'b1;
    sb_set_addr = 5'd3;
    rd_addr     = {5'd0, 5'd3};
    #1;
    chk("r3_busy_c0", {31'b0, rd_busy[0]}, 32'h0);
    tick();
    chk("r3_busy_c1", {31'b0, rd_busy[0]}, 32'h1);
    tick();
    chk("r3_full_c2", {31'b0, sb_full}, 32'h0);
    tick();
    chk("r3_full_c3", {31'b0, sb_full}, 32'h1);
    chk("r3_err_c3", {31'b0, sb_err}, 32'h0);
    tick();
    idle();
    #1;
    chk("r3_ovf_err", {31'b0, sb_err}, 32'h1);
    chk("r3_ovf_full", {31'b0, sb_full}, 32'h1);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {32'h0, 32'h0000_0031};
    #1;
    chk("r3_ret1_busy", {31'b0, rd_busy[0]}, 32'h1);
    tick();
    wr_data = {32'h0, 32'h0000_0032};
    #1;
    chk("r3_ret2_busy", {31'b0, rd_busy[0]}, 32'h1);
    tick();
    wr_data = {32'h0, 32'h0000_0033};
    #1;
    chk("r3_ret3_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("r3_ret3_byp", rd_data[31:0], 32'h0000_0033);
    tick();
    idle();
    #1;
    chk("r3_drained", {31'b0, rd_busy[0]}, 32'h0);
    chk("r3_notfull", {31'b0, sb_full}, 32'h0);
    chk("r3_arr", rd_data[31:0], 32'h0000_0033);

    // r9: count 1, then set and retire together keeps count 1.
    sb_set      = 1'b1;
    sb_set_addr = 5'd9;
    rd_addr     = {5'd9, 5'd0};
    tick();
    wr_en   = 2'b10;
    wr_addr = {5'd9, 5'd0};
    wr_data = {32'h0000_0099, 32'h0};
    #1;
    chk("r9_same_busy", {31'b0, rd_busy[1]}, 32'h0);
    chk("r9_same_byp", rd_data[63:32], 32'h0000_0099);
    tick();
    idle();
    #1;
    chk("r9_busy_kept", {31'b0, rd_busy[1]}, 32'h1);

    // Reset mid-sequence overrides a concurrent write and set.
    reset       = 1'b1;
    sb_set      = 1'b1;
    wr_en       = 2'b10;
    wr_data     = {32'h0000_0777, 32'h0};
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("mid_rst_busy", {31'b0, rd_busy[1]}, 32'h0);
    chk("mid_rst_err", {31'b0, sb_err}, 32'h0);
    chk("mid_rst_r9", rd_data[63:32], 32'h0);

    // Two retires against a count of 1 floor at zero and flag an error.
    sb_set      = 1'b1;
    sb_set_addr = 5'd4;
    rd_addr     = {5'd4, 5'd4};
    tick();
    idle();
    wr_en   = 2'b11;
    wr_addr = {5'd4, 5'd4};
    wr_data = {32'h0000_0444, 32'h0000_0440};
    #1;
    chk("r4_double_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("r4_err_pre", {31'b0, sb_err}, 32'h0);
    tick();
    idle();
    #1;
    chk("r4_err_post", {31'b0, sb_err}, 32'h1);
    chk("r4_busy_post", {31'b0, rd_busy[1]}, 32'h0);
    chk("r4_arr", rd_data[31:0], 32'h0000_0444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
